conv_accum_store: RTL and testbench

- Sits directly downstream of the conv window engine: consumes its per-pixel valid/out_pixel stream and returns save_done so the engine advances to the next output address.
- Accumulates partial sums across input channels in an internal 32-bit buffer, one entry per output pixel.
- On the last input channel, requantizes each sum to 8 bits and writes it to the output feature-map buffer.

---
 rtl/conv_accum_store_pkg.sv | 40 ++++
 rtl/conv_accum_store_if.sv | 36 +++
 rtl/conv_accum_store_requant_sat.sv | 59 +++++
 rtl/conv_accum_store.sv | 189 ++++++++++++++++++
 tb/tb_conv_accum_store.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_accum_store_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_accum_store_pkg
//  Description : Shared types, constants and saturation helpers for the
//                conv accumulate/requantize/store block.
//  Revision    : 1.0  initial release
// ============================================================================
package conv_accum_store_pkg;

    localparam int ACC_WIDTH   = 32;
    localparam int ADDR_WIDTH  = 8;
    localparam int OUT_N_CONV1 = 182;   // 14x13 output map
    localparam int OUT_N_CONV2 = 132;   // 12x11 output map

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    // Clamp a one-bit-wider signed sum back into the signed ACC_WIDTH range.
    function automatic logic signed [ACC_WIDTH-1:0] sat_signed(
        input logic signed [ACC_WIDTH:0] v
    );
        if (v[ACC_WIDTH] != v[ACC_WIDTH-1]) begin
            return v[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
        return v[ACC_WIDTH-1:0];
    endfunction

    // High when sat_signed would have to clamp its argument.
    function automatic logic sat_overflow(
        input logic signed [ACC_WIDTH:0] v
    );
        return v[ACC_WIDTH] ^ v[ACC_WIDTH-1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_accum_store_if.sv
`default_nettype none
// ============================================================================
//  Module      : conv_accum_store_if
//  Description : Pixel stream in / feature-map write out bundle between the
//                conv window engine, this block and the output buffer.
//  Revision    : 1.0  initial release
// ============================================================================
interface conv_accum_store_if
    import conv_accum_store_pkg::*;
#(
    parameter int IN_WIDTH   = 24,
    parameter int DATA_WIDTH = 8
) ();

    logic                         in_valid;
    logic signed [IN_WIDTH-1:0]   in_pixel;
    logic                         save_done;
    logic                         out_we;
    logic [ADDR_WIDTH-1:0]        out_addr;
    logic [DATA_WIDTH-1:0]        out_data;
    logic                         ch_done;

    // Engine / testbench side
    modport master (
        output in_valid, in_pixel,
        input  save_done, out_we, out_addr, out_data, ch_done
    );

    // Accumulate/store block side
    modport slave (
        input  in_valid, in_pixel,
        output save_done, out_we, out_addr, out_data, ch_done
    );

endinterface
`default_nettype wire

// File: rtl/conv_accum_store_requant_sat.sv
`default_nettype none
// ============================================================================
//  Module      : requant_sat
//  Description : Combinational round-half-up, arithmetic right shift and
//                clamp to an unsigned (conv1) or signed (conv2) output range.
//  Revision    : 1.0  initial release
// ============================================================================
module requant_sat #(
    parameter int ACC_WIDTH  = 32,
    parameter int DATA_WIDTH = 8
) (
    input  logic signed [ACC_WIDTH-1:0] i_sum,
    input  logic [4:0]                  i_shift,
    input  logic                        i_layer,
    output logic [DATA_WIDTH-1:0]       o_data,
    output logic                        o_sat
);
    import conv_accum_store_pkg::*;

    // One guard bit so the rounding constant can never overflow the sum.
    localparam int c_W = ACC_WIDTH + 1;
    localparam logic signed [c_W-1:0] c_ZERO = '0;
    localparam logic signed [c_W-1:0] c_UMAX = c_W'((1 << DATA_WIDTH) - 1);
    localparam logic signed [c_W-1:0] c_SMAX = c_W'((1 << (DATA_WIDTH-1)) - 1);
    localparam logic signed [c_W-1:0] c_SMIN = c_W'(-(1 << (DATA_WIDTH-1)));

    logic signed [c_W-1:0] w_ext;
    logic signed [c_W-1:0] w_rnd;
    logic signed [c_W-1:0] w_shifted;

    assign w_ext     = c_W'(i_sum);
    assign w_rnd     = (i_shift == 5'd0) ? c_ZERO : (c_W'(1) << (i_shift - 5'd1));
    assign w_shifted = (w_ext + w_rnd) >>> i_shift;

    // Clamp to the layer's output range and flag any clipping.
    always_comb begin
        o_data = w_shifted[DATA_WIDTH-1:0];
        o_sat  = 1'b0;
        if (!i_layer) begin
            if (w_shifted < c_ZERO) begin
                o_data = '0;
                o_sat  = 1'b1;
            end else if (w_shifted > c_UMAX) begin
                o_data = c_UMAX[DATA_WIDTH-1:0];
                o_sat  = 1'b1;
            end
        end else begin
            if (w_shifted < c_SMIN) begin
                o_data = c_SMIN[DATA_WIDTH-1:0];
                o_sat  = 1'b1;
            end else if (w_shifted > c_SMAX) begin
                o_data = c_SMAX[DATA_WIDTH-1:0];
                o_sat  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_accum_store.sv
`default_nettype none
// ============================================================================
//  Module      : conv_accum_store
//  Description : Accumulates conv partial sums across input channels in a
//                32-bit per-pixel buffer; on the last channel requantizes to
//                8 bits and writes the output feature map.
//  Revision    : 1.0  initial release
// ============================================================================
module conv_accum_store #(
    parameter int MAX_OUT    = 182,
    parameter int IN_WIDTH   = 24,
    parameter int ACC_WIDTH  = 32,   // must equal the package accumulator width
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    layer,
    input  logic                    first_ch,
    input  logic                    last_ch,
    input  logic [4:0]              shift,
    output logic                    sat_flag,
    conv_accum_store_if.slave       bus
);
    import conv_accum_store_pkg::*;

    state_t                         r_state;
    state_t                         w_state_next;
    logic                           w_take;
    logic                           w_acc_step;
    logic                           w_wb_step;

    logic [ADDR_WIDTH-1:0]          r_pix_idx;
    logic [ADDR_WIDTH-1:0]          w_last_idx;
    logic signed [IN_WIDTH-1:0]     r_pixel;
    logic                           r_first;
    logic                           r_last;
    logic                           r_layer;
    logic [4:0]                     r_shift;

    logic signed [ACC_WIDTH-1:0]    r_acc_mem [MAX_OUT];
    logic signed [ACC_WIDTH-1:0]    r_rd_data;
    logic signed [ACC_WIDTH:0]      w_px_ext;
    logic signed [ACC_WIDTH:0]      w_rd_ext;
    logic signed [ACC_WIDTH:0]      w_sum_wide;
    logic signed [ACC_WIDTH-1:0]    w_sum;
    logic                           w_acc_ovf;
    logic [DATA_WIDTH-1:0]          w_q;
    logic                           w_q_sat;

    logic                           r_save_done;
    logic                           r_out_we;
    logic                           r_ch_done;
    logic                           r_sat;
    logic [ADDR_WIDTH-1:0]          r_out_addr;
    logic [DATA_WIDTH-1:0]          r_out_data;

    // Pass length follows the layer latched at the start of the pixel.
    assign w_last_idx = r_layer ? ADDR_WIDTH'(OUT_N_CONV2 - 1)
                                : ADDR_WIDTH'(OUT_N_CONV1 - 1);

    // Partial sum: overwrite on channel 0, otherwise add to stored value.
    assign w_px_ext   = (ACC_WIDTH+1)'(r_pixel);
    assign w_rd_ext   = (ACC_WIDTH+1)'(r_rd_data);
    assign w_sum_wide = r_first ? w_px_ext : (w_rd_ext + w_px_ext);
    assign w_sum      = sat_signed(w_sum_wide);
    assign w_acc_ovf  = sat_overflow(w_sum_wide);

    requant_sat #(
        .ACC_WIDTH  (ACC_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_requant (
        .i_sum   (w_sum),
        .i_shift (r_shift),
        .i_layer (r_layer),
        .o_data  (w_q),
        .o_sat   (w_q_sat)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; clear aborts whatever pixel is in flight.
    always_comb begin
        w_state_next = r_state;
        w_take       = 1'b0;
        w_acc_step   = 1'b0;
        w_wb_step    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_take       = 1'b1;
                    w_state_next = S_ACC;
                end
            end
            S_ACC: begin
                w_acc_step   = 1'b1;
                w_state_next = S_WB;
            end
            S_WB: begin
                w_wb_step    = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (clear) begin
            w_take       = 1'b0;
            w_acc_step   = 1'b0;
            w_wb_step    = 1'b0;
            w_state_next = S_IDLE;
        end
    end

    // Accumulator RAM: synchronous read on accept, write-back of the new sum.
    always_ff @(posedge clk) begin
        if (w_take) begin
            r_rd_data <= r_acc_mem[r_pix_idx];
        end
        if (w_acc_step) begin
            r_acc_mem[r_pix_idx] <= w_sum;
        end
    end

    // Pass context, pixel index and registered output strobes. The strobes
    // are loaded as the sum completes so they are visible during S_WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_idx   <= '0;
            r_pixel     <= '0;
            r_first     <= 1'b0;
            r_last      <= 1'b0;
            r_layer     <= 1'b0;
            r_shift     <= '0;
            r_save_done <= 1'b0;
            r_out_we    <= 1'b0;
            r_ch_done   <= 1'b0;
            r_sat       <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
        end else begin
            r_save_done <= 1'b0;
            r_out_we    <= 1'b0;
            r_ch_done   <= 1'b0;
            if (clear) begin
                r_pix_idx <= '0;
            end
            if (w_take) begin
                r_pixel <= bus.in_pixel;
                r_first <= first_ch;
                r_last  <= last_ch;
                r_layer <= layer;
                r_shift <= shift;
            end
            if (w_acc_step) begin
                r_save_done <= 1'b1;
                r_out_we    <= r_last;
                r_ch_done   <= (r_pix_idx == w_last_idx);
                if (r_last) begin
                    r_out_addr <= r_pix_idx;
                    r_out_data <= w_q;
                end
                if (w_acc_ovf || (r_last && w_q_sat)) begin
                    r_sat <= 1'b1;
                end
            end
            if (w_wb_step) begin
                r_pix_idx <= (r_pix_idx == w_last_idx) ? '0
                                                       : r_pix_idx + ADDR_WIDTH'(1);
            end
        end
    end

    assign bus.save_done = r_save_done;
    assign bus.out_we    = r_out_we;
    assign bus.out_addr  = r_out_addr;
    assign bus.out_data  = r_out_data;
    assign bus.ch_done   = r_ch_done;
    assign sat_flag      = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_conv_accum_store.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_accum_store
//  Description : Self-checking bench for conv_accum_store with a behavioural
//                per-pixel accumulate/requantize reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_conv_accum_store;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       layer;
    logic       first_ch;
    logic       last_ch;
    logic [4:0] shift;
    logic       sat_flag;

    conv_accum_store_if bus ();

    conv_accum_store dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .layer    (layer),
        .first_ch (first_ch),
        .last_ch  (last_ch),
        .shift    (shift),
        .sat_flag (sat_flag),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    longint m_acc [182];
    int     m_idx = 0;
    bit     m_sat = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: what one absorbed pixel should produce.
    task automatic model_pixel(input longint px, output bit e_we, output logic [7:0] e_addr,
                               output logic [7:0] e_data, output bit e_ch);
        longint sum;
        longint q;
        int     n;
        n   = layer ? 132 : 182;
        sum = first_ch ? px : m_acc[m_idx] + px;
        if (sum > 64'sd2147483647) begin
            sum = 64'sd2147483647;   m_sat = 1'b1;
        end else if (sum < -64'sd2147483648) begin
            sum = -64'sd2147483648;  m_sat = 1'b1;
        end
        m_acc[m_idx] = sum;
        e_we   = last_ch;
        e_addr = m_idx[7:0];
        e_data = 8'h00;
        if (last_ch) begin
            q = sum;
            if (shift != 5'd0) q = q + (64'sd1 << (shift - 5'd1));
            q = q >>> shift;
            if (!layer) begin
                if (q < 0)        begin q = 0;    m_sat = 1'b1; end
                else if (q > 255) begin q = 255;  m_sat = 1'b1; end
            end else begin
                if (q < -128)     begin q = -128; m_sat = 1'b1; end
                else if (q > 127) begin q = 127;  m_sat = 1'b1; end
            end
            e_data = q[7:0];
        end
        e_ch  = (m_idx == n - 1);
        m_idx = e_ch ? 0 : m_idx + 1;
    endtask

    // Present one pixel, optionally holding in_valid into S_ACC, and check
    // the write-back cycle plus the quiet cycle after it.
    task automatic do_pixel(input longint px, input bit extra_valid);
        bit         e_we;
        bit         e_ch;
        logic [7:0] e_addr;
        logic [7:0] e_data;
        bus.in_valid = 1'b1;
        bus.in_pixel = px[23:0];
        @(negedge clk);
        bus.in_valid = extra_valid;
        check("acc_cycle_save_done", bus.save_done, 0);
        model_pixel(px, e_we, e_addr, e_data, e_ch);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("save_done", bus.save_done, 1);
        check("out_we", bus.out_we, e_we);
        check("ch_done", bus.ch_done, e_ch);
        check("sat_flag", sat_flag, m_sat);
        if (e_we) begin
            check("out_addr", bus.out_addr, e_addr);
            check("out_data", bus.out_data, e_data);
        end
        @(negedge clk);
        check("save_done_single", bus.save_done, 0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_idx = 0;
    endtask

    task automatic set_cfg(input bit l, input bit f, input bit la, input int sh);
        layer    = l;
        first_ch = f;
        last_ch  = la;
        shift    = sh[4:0];
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        longint px;
        rst = 1'b1; clear = 1'b0;
        bus.in_valid = 1'b0; bus.in_pixel = '0;
        set_cfg(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_save_done", bus.save_done, 0);
        check("rst_out_we", bus.out_we, 0);
        check("rst_out_addr", bus.out_addr, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_ch_done", bus.ch_done, 0);
        check("rst_sat", sat_flag, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single-channel conv1 pixel
        set_cfg(0, 1, 1, 4);
        do_pixel(100, 1'b0);
        check("tp1_data", bus.out_data, 8'd6);

        // Two-channel accumulate on pixel 5
        pulse_clear();
        set_cfg(1, 1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            px = (i == 5) ? -300 : longint'($urandom_range(0, 50));
            do_pixel(px, 1'b0);
        end
        pulse_clear();
        set_cfg(1, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            px = (i == 5) ? 250 : longint'($urandom_range(0, 50));
            do_pixel(px, 1'b0);
        end
        check("two_ch_data", bus.out_data, 8'hCE);
        check("two_ch_no_sat", sat_flag, 0);

        // Random three-channel conv1 map, passes back to back
        pulse_clear();
        for (int c = 0; c < 3; c++) begin
            set_cfg(0, c == 0, c == 2, 3);
            for (int i = 0; i < 182; i++) begin
                px = longint'($urandom_range(0, 600)) - 100;
                do_pixel(px, 1'b0);
            end
        end

        // in_valid held into S_ACC is ignored
        pulse_clear();
        set_cfg(0, 1, 1, 0);
        do_pixel(17, 1'b1);

        // clear during S_ACC aborts the pixel
        bus.in_valid = 1'b1;
        bus.in_pixel = 24'd55;
        @(negedge clk);
        bus.in_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_idx = 0;
        check("abort_save_done", bus.save_done, 0);
        check("abort_out_we", bus.out_we, 0);
        @(negedge clk);
        check("abort_save_done_late", bus.save_done, 0);
        do_pixel(33, 1'b0);

        // Output clamp and sticky sat_flag
        pulse_clear();
        set_cfg(1, 1, 1, 0);
        do_pixel(1000, 1'b0);
        check("clamp_data", bus.out_data, 8'd127);
        check("clamp_sat", sat_flag, 1);
        pulse_clear();
        check("sat_sticky_clear", sat_flag, 1);

        // Reset in the middle of a pass
        set_cfg(0, 1, 1, 3);
        for (int i = 0; i < 40; i++) begin
            px = longint'($urandom_range(0, 2000));
            do_pixel(px, 1'b0);
        end
        bus.in_valid = 1'b1;
        bus.in_pixel = 24'd77;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_idx = 0;
        m_sat = 1'b0;
        check("midrst_save_done", bus.save_done, 0);
        check("midrst_out_we", bus.out_we, 0);
        check("midrst_out_addr", bus.out_addr, 0);
        check("midrst_out_data", bus.out_data, 0);
        check("midrst_ch_done", bus.ch_done, 0);
        check("midrst_sat", sat_flag, 0);
        do_pixel(64, 1'b0);
        check("midrst_restart_addr", bus.out_addr, 0);

        // Accumulator saturation over many channels of full-scale input
        for (int k = 0; k < 300; k++) begin
            pulse_clear();
            set_cfg(0, k == 0, k == 299, 31);
            do_pixel(8388607, 1'b0);
        end
        check("accsat_data", bus.out_data, 8'd1);
        check("accsat_flag", sat_flag, 1);

        // conv2 pass wrap: ch_done on pixel 132, next pixel at address 0
        pulse_clear();
        set_cfg(1, 1, 1, int'($urandom_range(0, 31)));
        for (int i = 0; i < 132; i++) begin
            px = longint'($urandom_range(0, 16777215)) - 8388608;
            do_pixel(px, 1'b0);
        end
        do_pixel(5, 1'b0);
        check("wrap_addr", bus.out_addr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
